stream_mux_rr: RTL and testbench

Parametrised N-channel packet stream multiplexer with valid/ready handshakes, per-packet grant locking and a registered output stage. It is the next generation of our combinational bus muxes. It merges NUM_CH independent source streams onto one sink. The channel is selected either by an explicit select input or by round-robin arbitration, chosen at runtime. It sits between multiple producers and a single shared consumer, for example a shared bus or FIFO write port.

---
 rtl/stream_mux_rr_if.sv | 40 ++++
 rtl/stream_mux_rr.sv | 176 +++++++++++++++++
 tb/tb_stream_mux_rr.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_if
// Description : Bundle of per-channel source streams and the merged sink
//               stream used by stream_mux_rr.
//               slave  : the multiplexer side (takes in_*, drives out_*)
//               master : the surrounding producers and consumer
// Ports       : in_data/in_valid/in_last (sources -> mux)
//               in_ready (mux -> sources)
//               out_data/out_valid/out_last/out_ch (mux -> sink)
//               out_ready (sink -> mux)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if #(
   parameter int BUS_WIDTH = 8,
   parameter int NUM_CH    = 4
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [NUM_CH*BUS_WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]           in_valid;
   logic [NUM_CH-1:0]           in_last;
   logic [NUM_CH-1:0]           in_ready;
   logic [BUS_WIDTH-1:0]        out_data;
   logic                        out_valid;
   logic                        out_last;
   logic [SEL_W-1:0]            out_ch;
   logic                        out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_ch
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_ch
   );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : NUM_CH-to-1 packet stream multiplexer. Channel chosen by sel
//               (mode=0) or round-robin (mode=1); the grant is held for a
//               whole packet, and the output beat is registered.
// Ports       : clk, rst (sync, active high)
//               mode  - 0 manual select, 1 round-robin
//               sel   - manual channel index
//               bus   - stream_mux_rr_if slave port (sources + sink)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
   parameter int  BUS_WIDTH = 8,
   parameter int  NUM_CH    = 4,
   localparam int SEL_W     = $clog2(NUM_CH)
) (
   input wire              clk,
   input wire              rst,
   input wire              mode,
   input wire [SEL_W-1:0]  sel,
   stream_mux_rr_if.slave  bus
);

   localparam logic [SEL_W:0]   C_NUM_CH  = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] C_PTR_RST = SEL_W'(NUM_CH - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic [SEL_W-1:0]     r_g;
   logic [SEL_W-1:0]     r_ptr;

   logic                 r_out_valid;
   logic                 r_out_last;
   logic [BUS_WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0]     r_out_ch;

   logic                 w_load_ok;
   logic                 w_man_valid;
   logic                 w_rr_valid;
   logic [SEL_W-1:0]     w_rr_idx;
   logic                 w_cand_valid;
   logic [SEL_W-1:0]     w_cand_idx;
   logic                 w_gnt_en;
   logic [SEL_W-1:0]     w_gnt_idx;
   logic                 w_gnt_last;
   logic [BUS_WIDTH-1:0] w_gnt_data;
   logic [NUM_CH-1:0]    w_ready;
   logic                 w_xfer;

   // (base + offs) mod NUM_CH, with offs in 1..NUM_CH
   function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                 input int               offs);
      logic [SEL_W:0] sum;
      sum = {1'b0, base} + (SEL_W+1)'(offs);
      if (sum >= C_NUM_CH) begin
         sum = sum - C_NUM_CH;
      end
      return sum[SEL_W-1:0];
   endfunction

   assign w_load_ok = !r_out_valid || bus.out_ready;

   // Manual candidate: comparing against every legal index means an
   // out-of-range sel simply never matches.
   always_comb begin
      w_man_valid = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if ((sel == SEL_W'(k)) && bus.in_valid[k]) begin
            w_man_valid = 1'b1;
         end
      end
   end

   // Round-robin candidate: scanned from the far end so the last hit written
   // is the one nearest ptr+1.
   always_comb begin
      w_rr_valid = 1'b0;
      w_rr_idx   = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         if (bus.in_valid[rr_index(r_ptr, k)]) begin
            w_rr_valid = 1'b1;
            w_rr_idx   = rr_index(r_ptr, k);
         end
      end
   end

   assign w_cand_valid = mode ? w_rr_valid : w_man_valid;
   assign w_cand_idx   = mode ? w_rr_idx   : sel;

   // While locked the grant is fixed regardless of mode/sel/other valids.
   assign w_gnt_en  = (r_state == S_LOCKED) ? 1'b1 : w_cand_valid;
   assign w_gnt_idx = (r_state == S_LOCKED) ? r_g  : w_cand_idx;

   always_comb begin
      w_gnt_last = 1'b0;
      w_gnt_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_gnt_idx == SEL_W'(k)) begin
            w_gnt_last = bus.in_last[k];
            w_gnt_data = bus.in_data[k*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_xfer && !w_gnt_last) w_state_nxt = S_LOCKED;
         S_LOCKED: if (w_xfer &&  w_gnt_last) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // At most one ready bit is ever set, so only one channel can transfer.
   always_comb begin
      w_ready = '0;
      if (!rst && w_gnt_en && w_load_ok) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_gnt_idx == SEL_W'(k)) begin
               w_ready[k] = 1'b1;
            end
         end
      end
   end

   assign w_xfer = |(bus.in_valid & w_ready);

   // ------------------------------------------------- grant and pointer --
   always_ff @(posedge clk) begin
      if (rst) begin
         r_g   <= '0;
         r_ptr <= C_PTR_RST;
      end else if ((r_state == S_IDLE) && w_xfer) begin
         r_g   <= w_cand_idx;
         r_ptr <= w_cand_idx;
      end
   end

   // ------------------------------------------------------ output stage --
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_last  <= w_gnt_last;
         r_out_data  <= w_gnt_data;
         r_out_ch    <= w_gnt_idx;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Self-checking bench for stream_mux_rr (4-channel and
//               3-channel instances). Predicted output beats are queued when
//               stimulus is loaded and compared as the sink accepts them.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic [1:0] sel;
   logic       mode3;
   logic [1:0] sel3;

   always #5 clk = ~clk;

   stream_mux_rr_if #(.BUS_WIDTH(8), .NUM_CH(4)) bus  ();
   stream_mux_rr_if #(.BUS_WIDTH(8), .NUM_CH(3)) bus3 ();

   stream_mux_rr #(.BUS_WIDTH(8), .NUM_CH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .sel  (sel),
      .bus  (bus.slave)
   );

   stream_mux_rr #(.BUS_WIDTH(8), .NUM_CH(3)) dut3 (
      .clk  (clk),
      .rst  (rst),
      .mode (mode3),
      .sel  (sel3),
      .bus  (bus3.slave)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          n_out, first_cyc, last_cyc;
   int          block_owner = -1;
   int          block_ch    = -1;
   logic        stall_prev  = 1'b0;
   logic [10:0] held;

   // expected beat = {ch[1:0], last, data[7:0]}
   logic [10:0] sb_q[$];

   // per-channel source beats {last, data}
   logic [8:0]  src_mem [4][16];
   int          src_len [4];
   int          src_pos [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic add_beat(input int ch, input logic [7:0] d, input logic l);
      src_mem[ch][src_len[ch]] = {l, d};
      src_len[ch]++;
   endtask

   task automatic expect_beat(input int ch, input logic [7:0] d, input logic l);
      sb_q.push_back({ch[1:0], l, d});
   endtask

   task automatic clear_src();
      for (int k = 0; k < 4; k++) begin
         src_len[k] = 0;
         src_pos[k] = 0;
      end
   endtask

   function automatic logic pending();
      logic p = 1'b0;
      for (int k = 0; k < 4; k++) if (src_pos[k] < src_len[k]) p = 1'b1;
      return p;
   endfunction

   task automatic drive();
      logic [31:0] d;
      logic [3:0]  v, l;
      d = '0; v = '0; l = '0;
      for (int k = 0; k < 4; k++) begin
         if (src_pos[k] < src_len[k]) begin
            v[k]        = 1'b1;
            l[k]        = src_mem[k][src_pos[k]][8];
            d[k*8 +: 8] = src_mem[k][src_pos[k]][7:0];
         end
      end
      bus.in_valid = v;
      bus.in_last  = l;
      bus.in_data  = d;
   endtask

   // One clock: observe at the falling edge, advance sources after the rise.
   task automatic tick();
      logic [3:0]  hs;
      logic [10:0] e;
      @(negedge clk);
      hs = bus.in_valid & bus.in_ready;
      if (rst) check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      if (block_ch >= 0 && src_pos[block_owner] < src_len[block_owner])
         check("locked_in_ready", 32'(bus.in_ready[block_ch]), 32'd0);
      if (stall_prev) begin
         check("hold_data", 32'(bus.out_data), 32'(held[7:0]));
         check("hold_last", 32'(bus.out_last), 32'(held[8]));
         check("hold_ch",   32'(bus.out_ch),   32'(held[10:9]));
      end
      if (bus.out_valid && !bus.out_ready) begin
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         held       = {bus.out_ch, bus.out_last, bus.out_data};
         stall_prev = 1'b1;
      end else begin
         stall_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_ch",   32'(bus.out_ch),   32'(e[10:9]));
            check("out_last", 32'(bus.out_last), 32'(e[8]));
            check("out_data", 32'(bus.out_data), 32'(e[7:0]));
         end
         n_out++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 4; k++) if (hs[k]) src_pos[k]++;
      drive();
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((sb_q.size() != 0 || pending()) && n < max) begin
         tick();
         n++;
      end
      check("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic new_test();
      n_out = 0; first_cyc = -1; last_cyc = -1;
      block_owner = -1; block_ch = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mode = 1'b1; sel = 2'd0; mode3 = 1'b0; sel3 = 2'd3;
      bus.out_ready  = 1'b1;
      bus3.in_valid  = '0; bus3.in_last = '0; bus3.in_data = '0;
      bus3.out_ready = 1'b1;
      clear_src();
      drive();
      @(posedge clk); #1;

      // reset state
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_out_ch",    32'(bus.out_ch),    32'd0);

      // T1: round robin over single-beat packets
      new_test();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            add_beat(k, 8'(8'h40 + r*4 + k), 1'b1);
            expect_beat(k, 8'(8'h40 + r*4 + k), 1'b1);
         end
      end
      drive(); #1;
      check("rst_ready_gated", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("lat_before", 32'(bus.out_valid), 32'd0);
      tick();
      check("lat_first", 32'(bus.out_valid), 32'd1);
      drain(40);
      check("t1_no_bubble", 32'(last_cyc - first_cyc), 32'd7);

      // T2: packet lock in round-robin mode, ch2 waits then follows directly
      new_test();
      add_beat(1, 8'h11, 1'b0); add_beat(1, 8'h12, 1'b0); add_beat(1, 8'h13, 1'b1);
      add_beat(2, 8'h21, 1'b1);
      expect_beat(1, 8'h11, 1'b0); expect_beat(1, 8'h12, 1'b0);
      expect_beat(1, 8'h13, 1'b1); expect_beat(2, 8'h21, 1'b1);
      block_owner = 1; block_ch = 2;
      drive();
      drain(20);
      check("t2_no_bubble", 32'(last_cyc - first_cyc), 32'd3);

      // T3: manual select, sel change mid-packet is ignored
      new_test();
      mode = 1'b0; sel = 2'd2;
      add_beat(2, 8'h51, 1'b0); add_beat(2, 8'h52, 1'b0); add_beat(2, 8'h53, 1'b1);
      add_beat(0, 8'h50, 1'b1);
      expect_beat(2, 8'h51, 1'b0); expect_beat(2, 8'h52, 1'b0);
      expect_beat(2, 8'h53, 1'b1); expect_beat(0, 8'h50, 1'b1);
      block_owner = 2; block_ch = 0;
      drive();
      tick();
      sel = 2'd0;
      drain(20);
      check("t3_no_bubble", 32'(last_cyc - first_cyc), 32'd3);

      // T4: sink backpressure 1,0,0,1 during a 4-beat packet
      new_test();
      sel = 2'd0;
      for (int i = 0; i < 4; i++) begin
         add_beat(0, 8'(8'hA0 + i), i == 3);
         expect_beat(0, 8'(8'hA0 + i), i == 3);
      end
      drive();
      for (int i = 0; i < 4; i++) begin
         bus.out_ready = (i == 0 || i == 3);
         tick();
      end
      bus.out_ready = 1'b1;
      drain(20);
      check("t4_beats", 32'(n_out), 32'd4);

      // T5: 3-channel instance, out-of-range sel grants nothing
      bus3.in_valid = 3'b111; bus3.in_last = 3'b111; bus3.in_data = 24'h626160;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("n3_in_ready",  32'(bus3.in_ready),  32'd0);
         check("n3_out_valid", 32'(bus3.out_valid), 32'd0);
      end
      @(posedge clk); #1;
      sel3 = 2'd1;
      @(negedge clk);
      check("n3_sel1_ready", 32'(bus3.in_ready), 32'b010);
      @(posedge clk); #1;
      bus3.in_valid = '0;
      check("n3_sel1_valid", 32'(bus3.out_valid), 32'd1);
      check("n3_sel1_ch",    32'(bus3.out_ch),    32'd1);
      check("n3_sel1_data",  32'(bus3.out_data),  32'h61);

      // T6: reset in the middle of a packet
      new_test();
      mode = 1'b1;
      add_beat(1, 8'h31, 1'b0); add_beat(1, 8'h32, 1'b0); add_beat(1, 8'h33, 1'b1);
      expect_beat(1, 8'h31, 1'b0); expect_beat(1, 8'h32, 1'b0); expect_beat(1, 8'h33, 1'b1);
      drive();
      for (int i = 0; i < 10 && n_out < 1; i++) tick();
      check("t6_started", 32'(n_out), 32'd1);
      rst = 1'b1;
      tick();
      check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
      sb_q.delete();
      clear_src();
      rst = 1'b0;
      add_beat(1, 8'h71, 1'b1); add_beat(2, 8'h72, 1'b1);
      expect_beat(1, 8'h71, 1'b1); expect_beat(2, 8'h72, 1'b1);
      drive();
      check("t6_idle_out_valid", 32'(bus.out_valid), 32'd0);
      drain(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
